// File: rtl/serial_bit_counter_pkg.sv
// Shared types for the serial population counter.
// Exports: bc_state_t (control FSM states).
// No logic of its own; imported by the top and the datapath.
package serial_bit_counter_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    SCAN = 2'd1,
    DONE = 2'd2
  } bc_state_t;

endpackage

// File: rtl/serial_bit_counter_datapath.sv
// Datapath for the serial bit counter: shift register, count accumulator, scanned counter.
// Ports: clk/rst, control strobes load/step/clear, load_data/load_mode for a new word,
//        status lsb/rest_zero/last_bit for the FSM, registered count/scanned/mode results.
module bit_count_datapath
  import serial_bit_counter_pkg::*;
#(
  parameter int WIDTH = 10,
  parameter int CNT_W = $clog2(WIDTH + 1)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             load,
  input  logic             step,
  input  logic             clear,
  input  logic [WIDTH-1:0] load_data,
  input  logic             load_mode,
  output logic             lsb,
  output logic             rest_zero,
  output logic             last_bit,
  output logic [CNT_W-1:0] count,
  output logic [CNT_W-1:0] scanned,
  output logic             mode
);

  logic [WIDTH-1:0] sr;

  // The FSM never raises two strobes together; the priority only makes
  // clear (abort) win should that ever change.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sr      <= '0;
      count   <= '0;
      scanned <= '0;
      mode    <= 1'b0;
    end else if (clear) begin
      sr      <= '0;
      count   <= '0;
      scanned <= '0;
      mode    <= 1'b0;
    end else if (load) begin
      sr      <= load_data;
      count   <= '0;
      scanned <= '0;
      mode    <= load_mode;
    end else if (step) begin
      // CNT_W holds WIDTH exactly, so an all-ones word reaches WIDTH without wrapping.
      count   <= count + CNT_W'(sr[0]);
      scanned <= scanned + CNT_W'(1);
      sr      <= {1'b0, sr[WIDTH-1:1]};
    end
  end

  assign lsb       = sr[0];
  // True when the bit being consumed this cycle is the last countable one.
  assign rest_zero = (sr[WIDTH-1:1] == '0);
  // Pre-increment compare: this step consumes bit WIDTH-1.
  assign last_bit  = (scanned == CNT_W'(WIDTH - 1));

endmodule

// File: rtl/serial_bit_counter.sv
// Serial population counter: takes a WIDTH-bit word on in_valid/in_ready, scans LSB-first
// one bit per cycle counting ones (or zeros when in_mode=1), stopping early once no countable
// bits remain. Result held on out_valid/out_ready with out_count/out_scanned/out_mode; abort cancels.
module serial_bit_counter
  import serial_bit_counter_pkg::*;
#(
  parameter int WIDTH = 10,
  parameter int CNT_W = $clog2(WIDTH + 1)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_data,
  input  logic             in_mode,
  input  logic             abort,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [CNT_W-1:0] out_count,
  output logic [CNT_W-1:0] out_scanned,
  output logic             out_mode
);

  bc_state_t        state;
  bc_state_t        state_nxt;
  logic [WIDTH-1:0] eff;
  logic             accept;
  logic             load;
  logic             step;
  logic             clear;
  logic             lsb;
  logic             rest_zero;
  logic             last_bit;

  // Zero-counting is ones-counting of the inverted word, so the datapath
  // only ever counts ones.
  assign eff = in_mode ? ~in_data : in_data;

  assign in_ready  = (state == IDLE);
  assign out_valid = (state == DONE);
  // abort in IDLE leaves in_ready high but refuses the word.
  assign accept    = in_ready && in_valid && !abort;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    load      = 1'b0;
    step      = 1'b0;
    clear     = 1'b0;
    unique case (state)
      IDLE: begin
        if (accept) begin
          load = 1'b1;
          // Nothing countable: skip SCAN and present a zero result next cycle.
          state_nxt = (eff == '0) ? DONE : SCAN;
        end
      end
      SCAN: begin
        if (abort) begin
          clear     = 1'b1;
          state_nxt = IDLE;
        end else begin
          step = 1'b1;
          if (rest_zero || last_bit) begin
            state_nxt = DONE;
          end
        end
      end
      DONE: begin
        // abort wins over a same-cycle out_ready and wipes the result.
        if (abort) begin
          clear     = 1'b1;
          state_nxt = IDLE;
        end else if (out_ready) begin
          state_nxt = IDLE;
        end
      end
      default: begin
        state_nxt = IDLE;
      end
    endcase
  end

  bit_count_datapath #(
    .WIDTH (WIDTH),
    .CNT_W (CNT_W)
  ) u_datapath (
    .clk       (clk),
    .rst       (rst),
    .load      (load),
    .step      (step),
    .clear     (clear),
    .load_data (eff),
    .load_mode (in_mode),
    .lsb       (lsb),
    .rest_zero (rest_zero),
    .last_bit  (last_bit),
    .count     (out_count),
    .scanned   (out_scanned),
    .mode      (out_mode)
  );

endmodule

// File: tb/tb_serial_bit_counter.sv
module tb_serial_bit_counter;

  localparam int W  = 10;
  localparam int CW = 4;

  logic          clk = 1'b0;
  logic          rst;
  logic          in_valid;
  logic          in_ready;
  logic [W-1:0]  in_data;
  logic          in_mode;
  logic          abort;
  logic          out_valid;
  logic          out_ready;
  logic [CW-1:0] out_count;
  logic [CW-1:0] out_scanned;
  logic          out_mode;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  serial_bit_counter #(.WIDTH(W)) dut (
    .clk         (clk),
    .rst         (rst),
    .in_valid    (in_valid),
    .in_ready    (in_ready),
    .in_data     (in_data),
    .in_mode     (in_mode),
    .abort       (abort),
    .out_valid   (out_valid),
    .out_ready   (out_ready),
    .out_count   (out_count),
    .out_scanned (out_scanned),
    .out_mode    (out_mode)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  // Reference model: effective word, number of countable bits, and the
  // position of the highest countable bit plus one (bits scanned).
  function automatic int ref_eff(input logic [W-1:0] d, input logic m);
    int e;
    e = int'(d);
    if (m) e = (1 << W) - 1 - e;
    return e;
  endfunction

  function automatic int ref_count(input logic [W-1:0] d, input logic m);
    int e, n;
    e = ref_eff(d, m);
    n = 0;
    while (e != 0) begin
      n += e % 2;
      e = e / 2;
    end
    return n;
  endfunction

  function automatic int ref_scanned(input logic [W-1:0] d, input logic m);
    int e, n;
    e = ref_eff(d, m);
    n = 0;
    while (e != 0) begin
      e = e / 2;
      n++;
    end
    return n;
  endfunction

  // Full transaction: accept, measure latency, check result, hold under
  // backpressure for 'hold' cycles, then release.
  task automatic run_op(input logic [W-1:0] d, input logic m, input int hold);
    int cyc;
    int exp_c, exp_s;
    exp_c = ref_count(d, m);
    exp_s = ref_scanned(d, m);
    check("accept_in_ready", 32'(in_ready), 1);
    in_valid = 1'b1;
    in_data  = d;
    in_mode  = m;
    @(negedge clk);
    in_valid = 1'b0;
    in_data  = W'($urandom);
    in_mode  = 1'($urandom);
    cyc = 1;
    while (!out_valid && cyc < 40) begin
      @(negedge clk);
      cyc++;
    end
    check("latency", 32'(cyc), 32'(exp_s + 1));
    check("out_count", 32'(out_count), 32'(exp_c));
    check("out_scanned", 32'(out_scanned), 32'(exp_s));
    check("out_mode", 32'(out_mode), 32'(m));
    for (int i = 0; i < hold; i++) begin
      in_valid = 1'($urandom);
      in_data  = W'($urandom);
      @(negedge clk);
      check("hold_out_valid", 32'(out_valid), 1);
      check("hold_in_ready", 32'(in_ready), 0);
      check("hold_out_count", 32'(out_count), 32'(exp_c));
      check("hold_out_scanned", 32'(out_scanned), 32'(exp_s));
    end
    in_valid  = 1'b0;
    out_ready = 1'b1;
    @(negedge clk);
    out_ready = 1'b0;
    check("release_out_valid", 32'(out_valid), 0);
    check("release_in_ready", 32'(in_ready), 1);
    check("kept_out_count", 32'(out_count), 32'(exp_c));
  endtask

  initial begin
    int seen_valid;
    rst       = 1'b1;
    in_valid  = 1'b0;
    in_data   = '0;
    in_mode   = 1'b0;
    abort     = 1'b0;
    out_ready = 1'b0;
    repeat (2) @(negedge clk);
    check("rst_in_ready", 32'(in_ready), 1);
    check("rst_out_valid", 32'(out_valid), 0);
    check("rst_out_count", 32'(out_count), 0);
    check("rst_out_scanned", 32'(out_scanned), 0);
    check("rst_out_mode", 32'(out_mode), 0);
    rst = 1'b0;
    @(negedge clk);

    // Directed cases.
    run_op(10'h2B5, 1'b0, 0);
    run_op(10'h000, 1'b0, 0);
    run_op(10'h3F0, 1'b1, 0);
    run_op(10'h3FF, 1'b0, 1);
    run_op(10'h005, 1'b0, 5);
    run_op(10'h3FF, 1'b1, 0);

    // abort in IDLE refuses the word.
    in_valid = 1'b1;
    in_data  = 10'h0F0;
    abort    = 1'b1;
    @(negedge clk);
    in_valid = 1'b0;
    abort    = 1'b0;
    check("idle_abort_in_ready", 32'(in_ready), 1);
    @(negedge clk);
    check("idle_abort_no_result", 32'(out_valid), 0);

    // abort in the 3rd SCAN cycle.
    in_valid = 1'b1;
    in_data  = 10'h2B5;
    in_mode  = 1'b0;
    @(negedge clk);
    in_valid = 1'b0;
    repeat (2) @(negedge clk);
    abort = 1'b1;
    @(negedge clk);
    abort = 1'b0;
    check("scan_abort_in_ready", 32'(in_ready), 1);
    check("scan_abort_count", 32'(out_count), 0);
    check("scan_abort_scanned", 32'(out_scanned), 0);
    seen_valid = 0;
    for (int i = 0; i < 12; i++) begin
      @(negedge clk);
      if (out_valid) seen_valid = 1;
    end
    check("scan_abort_no_valid", 32'(seen_valid), 0);

    // abort in DONE beats a same-cycle out_ready and clears the result.
    in_valid = 1'b1;
    in_data  = 10'h00B;
    in_mode  = 1'b0;
    @(negedge clk);
    in_valid = 1'b0;
    repeat (4) @(negedge clk);
    check("pre_done_abort_valid", 32'(out_valid), 1);
    abort     = 1'b1;
    out_ready = 1'b1;
    @(negedge clk);
    abort     = 1'b0;
    out_ready = 1'b0;
    check("done_abort_in_ready", 32'(in_ready), 1);
    check("done_abort_count", 32'(out_count), 0);
    check("done_abort_scanned", 32'(out_scanned), 0);

    // Asynchronous reset mid-SCAN with mode latched high.
    in_valid = 1'b1;
    in_data  = 10'h14A;
    in_mode  = 1'b1;
    @(negedge clk);
    in_valid = 1'b0;
    repeat (2) @(negedge clk);
    #2 rst = 1'b1;
    #1;
    check("arst_in_ready", 32'(in_ready), 1);
    check("arst_out_valid", 32'(out_valid), 0);
    check("arst_out_count", 32'(out_count), 0);
    check("arst_out_scanned", 32'(out_scanned), 0);
    check("arst_out_mode", 32'(out_mode), 0);
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    run_op(10'h001, 1'b0, 0);

    // Randomized traffic against the reference model.
    for (int i = 0; i < 40; i++) begin
      run_op(W'($urandom), 1'($urandom), int'($urandom_range(0, 3)));
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
